// File: rtl/fetch_unit_if.sv
// Instruction-memory handshake: request/address from fetch, one-cycle ready/data from memory.
interface fetch_unit_if;
    localparam int unsigned XLEN = 32;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic [XLEN-1:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, imem handshake, flush/branch redirect, AdEL and delay-slot tagging.
// Define FETCH_BYPASS_EN to forward a response to F_ins in the cycle it arrives.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [31:0] IMEM_BASE  = 32'h0000_3000,
    parameter logic [31:0] IMEM_LAST  = 32'h0000_6ffc
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         pause,
    input  logic         br_valid,
    input  logic [31:0]  br_target,
    input  logic         d_is_jump,
    input  logic         exc_req,
    input  logic         eret_req,
    input  logic [31:0]  epc,
    fetch_unit_if.master imem,
    output logic [31:0]  F_ins,
    output logic [31:0]  F_PC,
    output logic [4:0]   F_exccode,
    output logic         F_lat,
    output logic         fetch_busy
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned ECW  = 5;
    localparam logic [ECW-1:0] EXC_NONE = ECW'(0);
    localparam logic [ECW-1:0] EXC_ADEL = ECW'(4);

    typedef enum logic [1:0] {S_FETCH, S_HOLD, S_DRAIN} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] hold_q, hold_d;

    logic            adel;
    logic            flush;
    logic [XLEN-1:0] flush_pc;
    logic [XLEN-1:0] next_pc;
    logic            req_c;
    logic [XLEN-1:0] ins_c;
    logic [ECW-1:0]  exc_c;
    logic            busy_c;

    assign adel     = (pc_q[1:0] != 2'b00) || (pc_q < IMEM_BASE) || (pc_q > IMEM_LAST);
    assign flush    = exc_req || eret_req;
    assign flush_pc = exc_req ? HANDLER_PC : epc;
    assign next_pc  = br_valid ? br_target : pc_q + XLEN'(4);

    // Next-state and F bundle; addr register reloads whenever a fresh request will start.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        hold_d  = hold_q;
        req_c   = 1'b0;
        ins_c   = '0;
        exc_c   = EXC_NONE;
        busy_c  = 1'b1;
        case (state_q)
            S_FETCH: begin
                if (adel) begin
                    exc_c  = EXC_ADEL;
                    busy_c = 1'b0;
                    if (flush)       pc_d = flush_pc;
                    else if (!pause) pc_d = next_pc;
                end else begin
                    req_c = 1'b1;
                    if (flush) begin
                        pc_d = flush_pc;
                        if (!imem.imem_ready) state_d = S_DRAIN;
                    end else if (imem.imem_ready) begin
`ifdef FETCH_BYPASS_EN
                        ins_c  = imem.imem_rdata;
                        busy_c = 1'b0;
                        if (!pause) begin
                            pc_d = next_pc;
                        end else begin
                            hold_d  = imem.imem_rdata;
                            state_d = S_HOLD;
                        end
`else
                        hold_d  = imem.imem_rdata;
                        state_d = S_HOLD;
`endif
                    end
                end
            end
            S_HOLD: begin
                ins_c  = hold_q;
                busy_c = 1'b0;
                if (flush) begin
                    pc_d    = flush_pc;
                    state_d = S_FETCH;
                end else if (!pause) begin
                    pc_d    = next_pc;
                    state_d = S_FETCH;
                end
            end
            S_DRAIN: begin
                // Stale request must complete on its original address before refetching.
                req_c = 1'b1;
                if (flush)            pc_d    = flush_pc;
                if (imem.imem_ready)  state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
        if (state_d == S_FETCH) addr_d = pc_d;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            hold_q  <= hold_d;
        end
    end

    // Reset values are forced on the outputs for as long as reset is held.
    assign imem.imem_req  = reset & req_c;
    assign imem.imem_addr = addr_q;
    assign F_ins          = reset ? ins_c  : '0;
    assign F_PC           = reset ? pc_q   : RESET_PC;
    assign F_exccode      = reset ? exc_c  : EXC_NONE;
    assign fetch_busy     = reset ? busy_c : 1'b1;
    assign F_lat          = d_is_jump;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized run against a PC-level model.
module tb_fetch_unit;
    localparam logic [31:0] RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
    localparam logic [31:0] IMEM_BASE  = 32'h0000_3000;
    localparam logic [31:0] IMEM_LAST  = 32'h0000_6ffc;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        pause = 1'b1;
    logic        br_valid = 1'b0;
    logic [31:0] br_target = '0;
    logic        d_is_jump = 1'b0;
    logic        exc_req = 1'b0;
    logic        eret_req = 1'b0;
    logic [31:0] epc = '0;
    logic [31:0] F_ins;
    logic [31:0] F_PC;
    logic [4:0]  F_exccode;
    logic        F_lat;
    logic        fetch_busy;

    fetch_unit_if imem();

    fetch_unit dut (
        .clk(clk), .reset(reset), .pause(pause), .br_valid(br_valid), .br_target(br_target),
        .d_is_jump(d_is_jump), .exc_req(exc_req), .eret_req(eret_req), .epc(epc), .imem(imem),
        .F_ins(F_ins), .F_PC(F_PC), .F_exccode(F_exccode), .F_lat(F_lat), .fetch_busy(fetch_busy)
    );

    int          checks = 0;
    int          failures = 0;
    int          cycle = 0;
    int          mem_lat = 2;
    bit          resp_en = 1'b1;
    bit          auto_pause = 1'b1;
    bit          extra_pause = 1'b0;
    logic [31:0] addr_log[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5a5a, ~a[15:0]};
    endfunction

    function automatic bit is_adel(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a < IMEM_BASE) || (a > IMEM_LAST);
    endfunction

    initial forever #5 clk = ~clk;

    // Memory responder (+2 after edge) and hazard-unit pause (+3 after edge).
    initial begin
        bit active = 1'b0;
        int age = 0;
        forever begin
            @(posedge clk);
            cycle++;
            #2;
            if (resp_en) begin
                imem.imem_ready = 1'b0;
                if (!imem.imem_req) begin
                    active = 1'b0;
                end else begin
                    if (!active) begin active = 1'b1; age = 0; end
                    else age++;
                    if (age >= mem_lat) begin
                        imem.imem_ready = 1'b1;
                        imem.imem_rdata = mem_word(imem.imem_addr);
                        active = 1'b0;
                    end
                end
            end
            #1;
            if (auto_pause) pause = fetch_busy | extra_pause;
        end
    end

    // Log the address of every newly started request.
    initial begin
        bit cont = 1'b0;
        forever begin
            @(negedge clk);
            if (imem.imem_req && !cont) addr_log.push_back(imem.imem_addr);
            cont = imem.imem_req && !imem.imem_ready;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        reset = 1'b0; exc_req = 1'b0; eret_req = 1'b0; br_valid = 1'b0; d_is_jump = 1'b0;
        extra_pause = 1'b0; auto_pause = 1'b1; mem_lat = 2;
        step();
        reset = 1'b1;
        addr_log.delete();
    endtask

    task automatic wait_bundle(output bit ok);
        int n = 0;
        @(negedge clk);
        while (fetch_busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        ok = !fetch_busy;
    endtask

    task automatic test_reset();
        resp_en = 1'b0;
        step();
        reset = 1'b0;
        imem.imem_ready = 1'b1;
        imem.imem_rdata = 32'hdead_beef;
        @(negedge clk);
        checks++; if (imem.imem_req !== 1'b0) begin failures++; $display("FAIL reset_req: got %b expected 0", imem.imem_req); end
        checks++; if (F_ins !== 32'h0) begin failures++; $display("FAIL reset_ins: got %h expected 0", F_ins); end
        checks++; if (F_PC !== RESET_PC) begin failures++; $display("FAIL reset_pc: got %h expected %h", F_PC, RESET_PC); end
        checks++; if (F_exccode !== 5'd0) begin failures++; $display("FAIL reset_exc: got %0d expected 0", F_exccode); end
        checks++; if (fetch_busy !== 1'b1) begin failures++; $display("FAIL reset_busy: got %b expected 1", fetch_busy); end
        step();
        reset = 1'b1;
        imem.imem_ready = 1'b0;
        resp_en = 1'b1;
        @(negedge clk);
        checks++;
        if ({fetch_busy, imem.imem_req, imem.imem_addr} !== {1'b1, 1'b1, RESET_PC}) begin
            failures++;
            $display("FAIL reset_first_req: got busy=%b req=%b addr=%h expected busy=1 req=1 addr=%h",
                     fetch_busy, imem.imem_req, imem.imem_addr, RESET_PC);
        end
    endtask

    task automatic test_sequential();
        bit ok;
        logic [31:0] exp_pc;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            exp_pc = RESET_PC + 32'(4 * k);
            wait_bundle(ok);
            checks++;
            if (!ok) begin failures++; $display("FAIL seq_timeout: no bundle for %h", exp_pc); end
            checks++;
            if ({F_PC, F_ins, F_exccode, F_lat} !== {exp_pc, mem_word(exp_pc), 5'd0, 1'b0}) begin
                failures++;
                $display("FAIL seq_bundle: got pc=%h ins=%h exc=%0d lat=%b expected pc=%h ins=%h exc=0 lat=0",
                         F_PC, F_ins, F_exccode, F_lat, exp_pc, mem_word(exp_pc));
            end
        end
        step();
        checks++;
        if (addr_log.size() < 3 || addr_log[0] !== 32'h3000 || addr_log[1] !== 32'h3004 || addr_log[2] !== 32'h3008) begin
            failures++;
            $display("FAIL seq_addr: got %p expected 3000,3004,3008", addr_log);
        end
    endtask

    task automatic test_branch();
        bit ok;
        do_reset();
        wait_bundle(ok);
        wait_bundle(ok);
        step();
        br_valid = 1'b1; br_target = 32'h3100; d_is_jump = 1'b1;
        wait_bundle(ok);
        checks++;
        if (!ok || {F_PC, F_ins, F_lat} !== {32'h3008, mem_word(32'h3008), 1'b1}) begin
            failures++;
            $display("FAIL delay_slot: got pc=%h ins=%h lat=%b expected pc=3008 ins=%h lat=1",
                     F_PC, F_ins, F_lat, mem_word(32'h3008));
        end
        step();
        br_valid = 1'b0; d_is_jump = 1'b0;
        wait_bundle(ok);
        checks++;
        if (!ok || {F_PC, F_ins, F_lat} !== {32'h3100, mem_word(32'h3100), 1'b0}) begin
            failures++;
            $display("FAIL branch_target: got pc=%h ins=%h lat=%b expected pc=3100 ins=%h lat=0",
                     F_PC, F_ins, F_lat, mem_word(32'h3100));
        end
        step();
        checks++;
        if (addr_log.size() < 2 || addr_log[addr_log.size()-1] !== 32'h3100 || addr_log[addr_log.size()-2] !== 32'h3008) begin
            failures++;
            $display("FAIL branch_addr: got %p expected ...,3008,3100", addr_log);
        end
    endtask

    task automatic test_exc_drain();
        bit ok;
        do_reset();
        for (int k = 0; k < 3; k++) wait_bundle(ok);
        mem_lat = 4;
        step();
        exc_req = 1'b1;
        step();
        exc_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({imem.imem_req, imem.imem_addr, fetch_busy} !== {1'b1, 32'h300c, 1'b1}) begin
                failures++;
                $display("FAIL drain_hold: got req=%b addr=%h busy=%b expected req=1 addr=300c busy=1",
                         imem.imem_req, imem.imem_addr, fetch_busy);
            end
        end
        mem_lat = 2;
        wait_bundle(ok);
        checks++;
        if (!ok || {F_PC, F_ins, F_exccode} !== {HANDLER_PC, mem_word(HANDLER_PC), 5'd0}) begin
            failures++;
            $display("FAIL exc_bundle: got pc=%h ins=%h exc=%0d expected pc=%h ins=%h exc=0",
                     F_PC, F_ins, F_exccode, HANDLER_PC, mem_word(HANDLER_PC));
        end
        step();
        checks++;
        if (addr_log.size() < 2 || addr_log[addr_log.size()-1] !== HANDLER_PC || addr_log[addr_log.size()-2] !== 32'h300c) begin
            failures++;
            $display("FAIL exc_addr: got %p expected ...,300c,4180", addr_log);
        end
    endtask

    task automatic test_eret_adel();
        bit ok;
        int n0;
        do_reset();
        wait_bundle(ok);
        step();
        eret_req = 1'b1; epc = 32'h3202;
        step();
        eret_req = 1'b0;
        wait_bundle(ok);
        n0 = addr_log.size();
        checks++;
        if (!ok || {F_PC, F_ins, F_exccode, imem.imem_req} !== {32'h3202, 32'h0, 5'd4, 1'b0}) begin
            failures++;
            $display("FAIL adel_misaligned: got pc=%h ins=%h exc=%0d req=%b expected pc=3202 ins=0 exc=4 req=0",
                     F_PC, F_ins, F_exccode, imem.imem_req);
        end
        step();
        eret_req = 1'b1; epc = 32'h7000;
        step();
        eret_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({F_PC, F_ins, F_exccode, imem.imem_req, fetch_busy} !== {32'h7000, 32'h0, 5'd4, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL adel_range: got pc=%h ins=%h exc=%0d req=%b busy=%b expected pc=7000 ins=0 exc=4 req=0 busy=0",
                     F_PC, F_ins, F_exccode, imem.imem_req, fetch_busy);
        end
        checks++;
        if (addr_log.size() != n0) begin
            failures++;
            $display("FAIL adel_no_req: got %0d requests expected %0d", addr_log.size(), n0);
        end
    endtask

    task automatic test_reset_hold();
        bit ok;
        do_reset();
        auto_pause = 1'b0;
        pause = 1'b1;
        wait_bundle(ok);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({fetch_busy, F_PC, F_ins, imem.imem_req} !== {1'b0, RESET_PC, mem_word(RESET_PC), 1'b0}) begin
                failures++;
                $display("FAIL hold_paused: got busy=%b pc=%h ins=%h req=%b expected busy=0 pc=3000 ins=%h req=0",
                         fetch_busy, F_PC, F_ins, imem.imem_req, mem_word(RESET_PC));
            end
        end
        step();
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({fetch_busy, F_PC, F_ins, F_exccode, imem.imem_req} !== {1'b1, RESET_PC, 32'h0, 5'd0, 1'b0}) begin
            failures++;
            $display("FAIL hold_reset: got busy=%b pc=%h ins=%h exc=%0d req=%b expected busy=1 pc=3000 ins=0 exc=0 req=0",
                     fetch_busy, F_PC, F_ins, F_exccode, imem.imem_req);
        end
        step();
        reset = 1'b1;
        auto_pause = 1'b1;
        addr_log.delete();
        wait_bundle(ok);
        step();
        checks++;
        if (!ok || addr_log.size() < 1 || addr_log[0] !== RESET_PC) begin
            failures++;
            $display("FAIL hold_restart: got %p expected first 3000", addr_log);
        end
    endtask

    task automatic test_latency();
        bit ok;
        int last_cyc;
        int exp_gap;
`ifdef FETCH_BYPASS_EN
        exp_gap = 2;
`else
        exp_gap = 3;
`endif
        do_reset();
        mem_lat = 1;
        last_cyc = -1;
        for (int k = 0; k < 4; k++) begin
            wait_bundle(ok);
            checks++;
            if (!ok || F_ins !== mem_word(F_PC)) begin
                failures++;
                $display("FAIL lat_ins: got ins=%h expected %h", F_ins, mem_word(F_PC));
            end
            checks++;
`ifdef FETCH_BYPASS_EN
            if (imem.imem_ready !== 1'b1) begin
                failures++;
                $display("FAIL lat_bypass: got ready=%b with bundle expected 1", imem.imem_ready);
            end
`else
            if (imem.imem_ready !== 1'b0) begin
                failures++;
                $display("FAIL lat_hold: got ready=%b with bundle expected 0", imem.imem_ready);
            end
`endif
            if (last_cyc >= 0) begin
                checks++;
                if (cycle - last_cyc != exp_gap) begin
                    failures++;
                    $display("FAIL lat_gap: got %0d cycles expected %0d", cycle - last_cyc, exp_gap);
                end
            end
            last_cyc = cycle;
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] prev_addr;
        bit prev_cont;
        int bundles;
        int sel;
        do_reset();
        exp_pc = RESET_PC;
        prev_cont = 1'b0;
        prev_addr = '0;
        bundles = 0;
        for (int i = 0; i < 1500; i++) begin
            step();
            exc_req  = ($urandom % 25) == 0;
            eret_req = ($urandom % 25) == 0;
            sel = int'($urandom % 8);
            if (sel == 0)      epc = 32'h3002 + 32'(4 * $urandom_range(0, 1023));
            else if (sel == 1) epc = 32'h7000 + 32'(4 * $urandom_range(0, 15));
            else               epc = IMEM_BASE + 32'(4 * $urandom_range(0, 4095));
            br_valid    = ($urandom % 4) == 0;
            br_target   = IMEM_BASE + 32'(4 * $urandom_range(0, 4095));
            d_is_jump   = ($urandom % 3) == 0;
            extra_pause = ($urandom % 4) == 0;
            mem_lat     = int'($urandom_range(1, 3));
            @(negedge clk);
            if (imem.imem_req) begin
                checks++;
                if (prev_cont && imem.imem_addr !== prev_addr) begin
                    failures++;
                    $display("FAIL rnd_addr_stable: got %h expected %h", imem.imem_addr, prev_addr);
                end else if (!prev_cont && imem.imem_addr !== exp_pc) begin
                    failures++;
                    $display("FAIL rnd_req_addr: got %h expected %h", imem.imem_addr, exp_pc);
                end
            end
            if (!fetch_busy) begin
                bundles++;
                checks++;
                if (is_adel(exp_pc)) begin
                    if ({F_PC, F_ins, F_exccode, F_lat, imem.imem_req} !== {exp_pc, 32'h0, 5'd4, d_is_jump, 1'b0}) begin
                        failures++;
                        $display("FAIL rnd_adel: got pc=%h ins=%h exc=%0d lat=%b req=%b expected pc=%h ins=0 exc=4 lat=%b req=0",
                                 F_PC, F_ins, F_exccode, F_lat, imem.imem_req, exp_pc, d_is_jump);
                    end
                end else if ({F_PC, F_ins, F_exccode, F_lat} !== {exp_pc, mem_word(exp_pc), 5'd0, d_is_jump}) begin
                    failures++;
                    $display("FAIL rnd_bundle: got pc=%h ins=%h exc=%0d lat=%b expected pc=%h ins=%h exc=0 lat=%b",
                             F_PC, F_ins, F_exccode, F_lat, exp_pc, mem_word(exp_pc), d_is_jump);
                end
            end
            prev_cont = imem.imem_req && !imem.imem_ready;
            prev_addr = imem.imem_addr;
            if (exc_req)                      exp_pc = HANDLER_PC;
            else if (eret_req)                exp_pc = epc;
            else if (!fetch_busy && !pause)   exp_pc = br_valid ? br_target : exp_pc + 32'd4;
        end
        step();
        exc_req = 1'b0; eret_req = 1'b0; br_valid = 1'b0; d_is_jump = 1'b0; extra_pause = 1'b0;
        checks++;
        if (bundles < 100) begin
            failures++;
            $display("FAIL rnd_progress: got %0d bundles expected at least 100", bundles);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_exc_drain();
        test_eret_adel();
        test_reset_hold();
        test_latency();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
